// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads, buffers responses in a small FIFO,
// and handles redirects. Optional misaligned-redirect trap: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] instr_pc_plus4,
    output logic                  fetch_fault
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pc, inflight_pc, redirect_tgt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc    [DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        occ_after;
    logic                  pop, wr, req, misaligned;
    logic                  unused_low_bits;

    assign redirect_tgt    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = (state == FAULT);
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // A killed response never lands, so only an unkilled one counts as a write.
    assign wr          = inflight & ~redirect;

    // Entries left after this cycle's write and pop; a new request must fit on top.
    assign occ_after = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign req       = (state == RUN) & ~redirect & (occ_after < (CNT_W+1)'(DEPTH));

    assign imem_req  = req;
    assign imem_addr = req ? pc : '0;

    // Head is read straight from storage; outputs are zero whenever nothing is valid.
    assign instr          = instr_valid ? buf_instr[head] : '0;
    assign instr_pc       = instr_valid ? buf_pc[head] : '0;
    assign instr_pc_plus4 = instr_valid ? buf_pc[head] + DATA_WIDTH'(4) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (redirect && misaligned) state_nxt = FAULT;
            FAULT:   if (redirect && !misaligned) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= req;
            if (req) inflight_pc <= pc;
            if (redirect) begin
                pc    <= redirect_tgt;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (req) pc <= pc + DATA_WIDTH'(4);
                if (wr)  tail <= tail + PTR_W'(1);
                if (pop) head <= head + PTR_W'(1);
                count <= count + CNT_W'(wr) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            buf_instr[tail] <= imem_rdata;
            buf_pc[tail]    <= inflight_pc;
        end
    end
endmodule
